// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: controller state encoding, default opcodes and the
// 1149.1 next-state table.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SH_DR    = 4'h2,
    EX1_DR   = 4'h1,
    PAUSE_DR = 4'h3,
    EX2_DR   = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SH_IR    = 4'hA,
    EX1_IR   = 4'h9,
    PAUSE_IR = 4'hB,
    EX2_IR   = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_e;

  localparam logic [4:0]  IDCODE_IR_DEF    = 5'h01;
  localparam logic [4:0]  BYPASS_IR_DEF    = 5'h1F;
  localparam logic [31:0] IDCODE_VALUE_DEF = 32'hDEB11001;

  function automatic tap_state_e tap_next_state(input tap_state_e state, input logic tms);
    tap_state_e nxt;
    case (state)
      TLR:      nxt = tms ? TLR    : RTI;
      RTI:      nxt = tms ? SEL_DR : RTI;
      SEL_DR:   nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR:   nxt = tms ? EX1_DR : SH_DR;
      SH_DR:    nxt = tms ? EX1_DR : SH_DR;
      EX1_DR:   nxt = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: nxt = tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   nxt = tms ? UPD_DR : SH_DR;
      UPD_DR:   nxt = tms ? SEL_DR : RTI;
      SEL_IR:   nxt = tms ? TLR    : CAP_IR;
      CAP_IR:   nxt = tms ? EX1_IR : SH_IR;
      SH_IR:    nxt = tms ? EX1_IR : SH_IR;
      EX1_IR:   nxt = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: nxt = tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   nxt = tms ? UPD_IR : SH_IR;
      UPD_IR:   nxt = tms ? SEL_DR : RTI;
      default:  nxt = TLR;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller: state register advanced by tms on rising tck,
// forced to Test-Logic-Reset while trst_n is low.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       tck,
  input  logic       trst_n,
  input  logic       tms,
  output logic [3:0] state
);

  tap_state_e state_q;
  tap_state_e state_d;

  always_comb begin
    state_d = tap_next_state(state_q, tms);
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state_q <= TLR;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/jtag_tap_slave.sv
// TAP responder: instruction register, IDCODE/BYPASS data registers, user DR
// strobes and the falling-edge tdo driver.
module jtag_tap_slave
  import jtag_tap_pkg::*;
#(
  parameter int                  IR_WIDTH     = 5,
  parameter logic [31:0]         IDCODE_VALUE = IDCODE_VALUE_DEF,
  parameter logic [IR_WIDTH-1:0] IDCODE_IR    = IR_WIDTH'(IDCODE_IR_DEF),
  parameter logic [IR_WIDTH-1:0] BYPASS_IR    = {IR_WIDTH{1'b1}}
) (
  input  logic                tck,
  input  logic                trst_n,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  output logic [IR_WIDTH-1:0] ir_out,
  output logic                user_sel,
  output logic                capture_dr,
  output logic                shift_dr,
  output logic                update_dr,
  input  logic                user_tdo
);

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  logic [3:0]          state_raw;
  tap_state_e          state;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
  logic [31:0]         idcode_q, idcode_d;
  logic                bypass_q, bypass_d;
  logic                tdo_q, tdo_d;
  logic                tdo_en_q, tdo_en_d;
  logic                is_idcode, is_bypass;

  jtag_tap_fsm u_fsm (
    .tck    (tck),
    .trst_n (trst_n),
    .tms    (tms),
    .state  (state_raw)
  );

  assign state     = tap_state_e'(state_raw);
  assign is_idcode = (ir_q == IDCODE_IR);
  assign is_bypass = (ir_q == BYPASS_IR);
  assign user_sel  = !(is_idcode || is_bypass);

  // User DRs live outside; they act on these strobes at the same rising edge.
  assign capture_dr = user_sel && (state == CAP_DR);
  assign shift_dr   = user_sel && (state == SH_DR);
  assign update_dr  = user_sel && (state == UPD_DR);

  always_comb begin
    ir_d     = ir_q;
    ir_sr_d  = ir_sr_q;
    idcode_d = idcode_q;
    bypass_d = bypass_q;
    case (state)
      TLR:    ir_d    = IDCODE_IR;
      CAP_IR: ir_sr_d = IR_CAPTURE;
      SH_IR:  ir_sr_d = {tdi, ir_sr_q[IR_WIDTH-1:1]};
      UPD_IR: ir_d    = ir_sr_q;
      CAP_DR: begin
        if (is_idcode)      idcode_d = IDCODE_VALUE;
        else if (is_bypass) bypass_d = 1'b0;
      end
      SH_DR: begin
        if (is_idcode)      idcode_d = {tdi, idcode_q[31:1]};
        else if (is_bypass) bypass_d = tdi;
      end
      default: ;
    endcase
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir_q     <= IDCODE_IR;
      ir_sr_q  <= '0;
      idcode_q <= IDCODE_VALUE;
      bypass_q <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      ir_sr_q  <= ir_sr_d;
      idcode_q <= idcode_d;
      bypass_q <= bypass_d;
    end
  end

  always_comb begin
    tdo_d = tdo_q;
    if (state == SH_IR) begin
      tdo_d = ir_sr_q[0];
    end else if (state == SH_DR) begin
      tdo_d = is_idcode ? idcode_q[0] : (is_bypass ? bypass_q : user_tdo);
    end
    tdo_en_d = (state == SH_IR) || (state == SH_DR);
  end

  // tdo launches on the falling edge so the host samples a settled bit.
  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign tdo    = tdo_q;
  assign tdo_en = tdo_en_q;
  assign ir_out = ir_q;

endmodule

// File: tb/tb_jtag_tap_slave.sv
// Scoreboard bench for jtag_tap_slave: scans queue their expected tdo bits,
// a posedge monitor pops one per valid tdo bit and compares.
module tb_jtag_tap_slave;

  localparam int          W      = 5;
  localparam logic [31:0] IDCODE = 32'hDEB11001;

  logic         tck = 1'b0;
  logic         trst_n = 1'b1;
  logic         tms = 1'b1;
  logic         tdi = 1'b0;
  logic         user_tdo = 1'b0;
  logic         tdo, tdo_en, user_sel, capture_dr, shift_dr, update_dr;
  logic [W-1:0] ir_out;

  int           tests = 0;
  int           fails = 0;
  logic         sb_q[$];
  logic         mon_exp;
  logic [W-1:0] model_ir = 5'h01;

  jtag_tap_slave #(
    .IR_WIDTH     (W),
    .IDCODE_VALUE (IDCODE),
    .IDCODE_IR    (5'h01),
    .BYPASS_IR    (5'h1F)
  ) dut (
    .tck        (tck),
    .trst_n     (trst_n),
    .tms        (tms),
    .tdi        (tdi),
    .tdo        (tdo),
    .tdo_en     (tdo_en),
    .ir_out     (ir_out),
    .user_sel   (user_sel),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .user_tdo   (user_tdo)
  );

  always #5 tck = ~tck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // tdo only changes on falling tck, so sampling it at rising tck is safe.
  always @(posedge tck) begin
    if (trst_n && tdo_en) begin
      if (sb_q.size() == 0) begin
        chk("tdo_unexpected", 32'(tdo_en), 32'(1'b0));
      end else begin
        mon_exp = sb_q.pop_front();
        chk("tdo", 32'(tdo), 32'(mon_exp));
      end
    end
  end

  task automatic tick(input logic m, input logic d, input logic u);
    tms = m;
    tdi = d;
    user_tdo = u;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  function automatic logic exp_user();
    return (model_ir != 5'h01) && (model_ir != 5'h1F);
  endfunction

  task automatic chk_pins(input logic en, input logic [2:0] st);
    chk("tdo_en", 32'(tdo_en), 32'(en));
    chk("strobes", 32'({capture_dr, shift_dr, update_dr}), 32'(st));
  endtask

  // Reference chain model: the selected register is a FIFO of bits, LSB at the
  // front; every shift emits the front bit and appends tdi at the back.
  task automatic build_exp(input bit is_ir, input int n, input logic [63:0] tv,
                           input logic [63:0] uv, output logic [W-1:0] reg_after);
    logic        mq[$];
    logic [31:0] idv;
    bit          user;
    idv = IDCODE;
    user = !is_ir && exp_user();
    reg_after = model_ir;
    if (is_ir) begin
      for (int j = 0; j < W; j++) mq.push_back(j == 0);
    end else if (model_ir == 5'h01) begin
      for (int j = 0; j < 32; j++) mq.push_back(idv[j]);
    end else begin
      mq.push_back(1'b0);
    end
    for (int i = 0; i < n; i++) begin
      if (user) begin
        sb_q.push_back(uv[i]);
      end else begin
        sb_q.push_back(mq.pop_front());
        mq.push_back(tv[i]);
      end
    end
    if (is_ir) begin
      for (int j = 0; j < W; j++) reg_after[j] = mq[j];
    end
  endtask

  // Full scan from Run-Test/Idle back to Run-Test/Idle, optional pause after
  // shift number pause_at.
  task automatic scan(input bit is_ir, input int n, input logic [63:0] tv,
                      input logic [63:0] uv, input int pause_at);
    logic [W-1:0] new_ir;
    logic [W-1:0] old_ir;
    logic         u;
    bit           last, pz;
    old_ir = model_ir;
    u = is_ir ? 1'b0 : exp_user();
    build_exp(is_ir, n, tv, uv, new_ir);
    tick(1'b1, 1'b0, 1'b0); chk_pins(1'b0, 3'b000);
    if (is_ir) begin
      tick(1'b1, 1'b0, 1'b0); chk_pins(1'b0, 3'b000);
    end
    tick(1'b0, 1'b0, 1'b0); chk_pins(1'b0, {u, 2'b00});
    tick(1'b0, 1'b0, uv[0]); chk_pins(1'b1, {1'b0, u, 1'b0});
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      pz = (i + 1 == pause_at) && !last;
      tick(last || pz, tv[i], uv[i+1]);
      if (last || pz) chk_pins(1'b0, 3'b000);
      else            chk_pins(1'b1, {1'b0, u, 1'b0});
      if (pz) begin
        tick(1'b0, 1'b0, uv[i+1]); chk_pins(1'b0, 3'b000);
        tick(1'b0, 1'b0, uv[i+1]); chk_pins(1'b0, 3'b000);
        tick(1'b1, 1'b0, uv[i+1]); chk_pins(1'b0, 3'b000);
        tick(1'b0, 1'b0, uv[i+1]); chk_pins(1'b1, {1'b0, u, 1'b0});
      end
    end
    tick(1'b1, 1'b0, 1'b0); chk_pins(1'b0, {2'b00, u});
    chk("ir_hold", 32'(ir_out), 32'(old_ir));
    tick(1'b0, 1'b0, 1'b0); chk_pins(1'b0, 3'b000);
    if (is_ir) model_ir = new_ir;
    chk("ir_out", 32'(ir_out), 32'(model_ir));
    chk("user_sel", 32'(user_sel), 32'(exp_user()));
    chk("sb_drained", sb_q.size(), 0);
    $display("[TB] %s scan n=%0d pause=%0d ir=%02h", is_ir ? "IR" : "DR", n, pause_at, model_ir);
  endtask

  task automatic tms_abort(input int k);
    logic [63:0]  tv, uv;
    logic [W-1:0] unused_ir;
    tv = {$urandom, $urandom};
    uv = {$urandom, $urandom};
    build_exp(1'b0, k + 1, tv, uv, unused_ir);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, uv[0]);
    for (int i = 0; i < k; i++) tick(1'b0, tv[i], uv[i+1]);
    tick(1'b1, tv[k], 1'b0);
    repeat (4) tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    model_ir = 5'h01;
    chk("abort_ir_out", 32'(ir_out), 32'(model_ir));
    chk("abort_user_sel", 32'(user_sel), 32'(1'b0));
    chk("abort_tdo_en", 32'(tdo_en), 32'(1'b0));
    chk("sb_drained", sb_q.size(), 0);
    $display("[TB] tms reset after %0d DR shifts", k);
  endtask

  task automatic trst_mid_ir();
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("shir_tdo", 32'(tdo), 32'(1'b1));
    chk("shir_tdo_en", 32'(tdo_en), 32'(1'b1));
    #2 trst_n = 1'b0;
    #1;
    chk("trst_tdo", 32'(tdo), 32'(1'b0));
    chk("trst_tdo_en", 32'(tdo_en), 32'(1'b0));
    chk("trst_ir_out", 32'(ir_out), 32'(5'h01));
    @(negedge tck);
    #1 trst_n = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    model_ir = 5'h01;
    chk("post_trst_ir_out", 32'(ir_out), 32'(model_ir));
    chk("sb_drained", sb_q.size(), 0);
    $display("[TB] trst_n pulse during Shift-IR");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int           n, r, pa;
    logic [W-1:0] op;
    #1 trst_n = 1'b0;
    @(negedge tck);
    #1;
    chk("rst_tdo", 32'(tdo), 32'(1'b0));
    chk("rst_tdo_en", 32'(tdo_en), 32'(1'b0));
    chk("rst_ir_out", 32'(ir_out), 32'(5'h01));
    chk("rst_user_sel", 32'(user_sel), 32'(1'b0));
    chk("rst_strobes", 32'({capture_dr, shift_dr, update_dr}), 32'(3'b000));
    trst_n = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk("rti_ir_out", 32'(ir_out), 32'(5'h01));
    chk("rti_tdo_en", 32'(tdo_en), 32'(1'b0));
    $display("[TB] reset then Run-Test/Idle");

    scan(1'b0, 32, 64'h0, 64'h0, 0);
    scan(1'b1, 5, 64'h1F, 64'h0, 0);
    scan(1'b0, 4, 64'hD, 64'h0, 0);
    trst_mid_ir();
    scan(1'b1, 5, 64'h11, 64'h0, 0);
    scan(1'b0, 3, {$urandom, $urandom}, {$urandom, $urandom}, 0);
    tms_abort(3);

    for (int t = 0; t < 30; t++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        case ($urandom_range(0, 2))
          0:       op = 5'h01;
          1:       op = 5'h1F;
          default: op = W'($urandom);
        endcase
        if ($urandom_range(0, 9) < 7) scan(1'b1, W, 64'(op), 64'h0, 0);
        else scan(1'b1, $urandom_range(1, 9), {$urandom, $urandom}, 64'h0, 0);
      end else if (r <= 7) begin
        n = $urandom_range(1, 40);
        pa = (n > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : 0;
        scan(1'b0, n, {$urandom, $urandom}, {$urandom, $urandom}, pa);
      end else if (r == 8) begin
        tms_abort($urandom_range(0, 5));
      end else begin
        trst_mid_ir();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtag_tap_slave.md
Name: jtag_tap_slave

Overview:
- Synthesizable IEEE 1149.1 TAP responder: the DUT-side end of the jtag_if bus (tms/tck/tdi/tdo/trst_n) that the simulation JTAG driver initiates on.
- Implements the 16-state TAP FSM, instruction register, IDCODE and BYPASS data registers.
- Exposes a capture/shift/update strobe interface so debug-module data registers can sit behind user instructions.
- Sits between jtag_if and the core's debug transport.

Parameters:
- IR_WIDTH, 5, instruction register width (>=2)
- IDCODE_VALUE, 32'hDEB11001, value captured by IDCODE; bit0 must be 1
- IDCODE_IR, 5'h01, opcode selecting IDCODE; also the value loaded on reset/Test-Logic-Reset
- BYPASS_IR, all ones, opcode selecting BYPASS

Ports:
- tck  input  1  TAP clock (the block's only clock)
- trst_n  input  1  asynchronous active-low reset
- tms  input  1  mode select, sampled on rising tck
- tdi  input  1  serial data in, sampled on rising tck
- tdo  output  1  serial data out, changes on falling tck
- tdo_en  output  1  tdo valid (Shift-IR/Shift-DR), changes on falling tck
- ir_out  output  IR_WIDTH  current instruction
- user_sel  output  1  ir_out is neither IDCODE_IR nor BYPASS_IR
- capture_dr  output  1  state==Capture-DR and user_sel
- shift_dr  output  1  state==Shift-DR and user_sel
- update_dr  output  1  state==Update-DR and user_sel
- user_tdo  input  1  LSB of the external selected DR

Behaviour:
- Reset (trst_n=0, async, both edges' flops): state=TLR, ir_out=IDCODE_IR, IR shift reg=0, idcode shift=IDCODE_VALUE, bypass=0, tdo=0, tdo_en=0.
- FSM, rising tck, next state by tms (tms=0 / tms=1):
  - TLR: RTI / TLR
  - RTI: RTI / SelDR
  - SelDR: CapDR / SelIR
  - CapDR: ShDR / Ex1DR
  - ShDR: ShDR / Ex1DR
  - Ex1DR: PauseDR / UpdDR
  - PauseDR: PauseDR / Ex2DR
  - Ex2DR: ShDR / UpdDR
  - UpdDR: RTI / SelDR
  - SelIR: CapIR / TLR
  - IR branch mirrors the DR branch: CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR.
- Five consecutive rising tck with tms=1 reach TLR from any state.
- In TLR at rising tck: ir_out <= IDCODE_IR.
- IR path, rising tck:
  - In CapIR: IR shift reg <= {0..., 2'b01}.
  - In ShIR: IR shift reg <= {tdi, sr[IR_WIDTH-1:1]}.
  - In UpdIR: ir_out <= IR shift reg.
  - ir_out is unchanged in every other state.
- DR path, rising tck, selected by ir_out:
  - IDCODE: CapDR loads IDCODE_VALUE; ShDR shifts right with tdi into bit31.
  - BYPASS: CapDR loads 0; ShDR loads tdi.
  - User: no internal register. External logic acts on the strobes at the same rising edge. Strobes are combinational decodes of the state register and ir_out.
- tdo, falling tck:
  - In ShIR: tdo <= IR sr[0].
  - In ShDR: tdo <= the selected source (idcode[0], bypass, or user_tdo).
  - Otherwise tdo holds.
  - tdo_en <= (state==ShIR or ShDR).
- Latency: first captured bit appears on tdo at the falling edge after the rising edge that enters ShDR/ShIR. Each subsequent bit follows one tck later.
- BYPASS delays tdi→tdo by exactly one tck.
- Reset mid-shift aborts the scan. ir_out returns to IDCODE_IR, and no Update occurs.
- Exit/Pause states hold shift registers unchanged.
- An IR update to an unknown opcode yields user_sel=1. Strobes fire only while user_sel=1.

Decomposition:
- Package jtag_tap_pkg:
  - enum tap_state_e (16 states, 4-bit encoding)
  - default IDCODE/BYPASS opcode constants
  - function tap_next_state(state, tms)
- One natural sub-module: jtag_tap_fsm (state register plus next-state logic, outputs state).
- The top level holds the IR, the DRs and the tdo mux.

Test Plan:
- trst_n=0 pulse, then tms=0 for one tck → state RTI, ir_out=5'h01, tdo_en=0.
- From RTI, go to ShDR and shift 32 bits with tdi=0 → tdo sequence LSB-first equals 32'hDEB11001; tdo_en=1 only during the shift.
- Scan IR with tdi pattern 5'b11111 → the 5 captured bits read 1,0,0,0,0. After UpdIR, ir_out=5'h1F and user_sel=0.
- BYPASS selected, shift DR with tdi=1,0,1,1 → tdo=0 (captured),1,0,1: one-cycle delay.
- Load IR=5'h11, do CapDR/ShDR×3/UpdDR → user_sel=1; capture_dr, shift_dr and update_dr each asserted in their states; tdo follows user_tdo.
- Mid-ShDR: tms=1 for 5 tck → TLR and ir_out=5'h01. Separately, trst_n=0 mid-ShIR → async return to TLR, tdo=0, tdo_en=0, no IR update.
